// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter family and a clog2 helper for callers
// that derive a counter width from a modulus.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        v = (value > 1) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic for the modulo counter: step, boundary detect and wrap.
// Zero latency; no flow control, the caller decides whether next_q is taken.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             en,
    output logic [WIDTH-1:0] next_q,
    output logic             at_boundary,
    output logic             wrap_next
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    // Up boundary: q+1 reaches MODULUS. Down boundary: q-1 borrows out of WIDTH bits.
    always_comb begin
        q_ext       = {1'b0, q};
        inc         = q_ext + 1'b1;
        dec         = q_ext - 1'b1;
        at_boundary = (up_dn == DIR_UP) ? (inc == MOD_EXT) : dec[WIDTH];
        next_q      = q;
        wrap_next   = 1'b0;
        if (en) begin
            if (!at_boundary) begin
                next_q = (up_dn == DIR_UP) ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
            end else if (SATURATE == MODE_WRAP) begin
                next_q    = (up_dn == DIR_UP) ? '0 : TOP_VAL;
                wrap_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with load, wrap/saturate and cascade tc; optional sticky
// overflow flag under MOD_UPDOWN_COUNTER_OVF_EN. q/wrap one cycle, tc combinational.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter int              SATURATE  = MODE_WRAP,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef MOD_UPDOWN_COUNTER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("mod_updown_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] next_q;
    logic             at_boundary;
    logic             wrap_next;
    logic [WIDTH-1:0] load_clamped;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .SATURATE(SATURATE)
    ) u_next (
        .q          (count_q),
        .up_dn      (up_dn),
        .en         (en),
        .next_q     (next_q),
        .at_boundary(at_boundary),
        .wrap_next  (wrap_next)
    );

    always_comb begin
        load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : TOP_VAL;
        count_d      = count_q;
        wrap_d       = 1'b0;
        if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            count_d = next_q;
            wrap_d  = wrap_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Deliberately not gated by load/reset: the next stage applies its own priority.
    assign tc   = en & at_boundary;
    assign q    = count_q;
    assign wrap = wrap_q;

`ifdef MOD_UPDOWN_COUNTER_OVF_EN
    logic ovf_q, ovf_d;

    // An enabled step at the boundary is either a wrap or a saturated hold.
    always_comb begin
        ovf_d = load ? 1'b0 : (ovf_q | (en & at_boundary));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down modulo counter.
- Successor to the fixed 4-bit ripple counter: one clock domain, no ripple clocking.
- Adds enable, direction, parallel load, programmable modulus, wrap/saturate mode, and cascade terminal-count.
- Used standalone as a divider/timer, or chained through tc as a multi-digit counter (e.g. BCD stages).

Parameters:
- WIDTH, 4, counter register width in bits (1..32).
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2..2**WIDTH; elaboration error outside it.
- SATURATE, 0, 0 = wrap at the boundary; 1 = hold at the boundary.
- RESET_VAL, 0, value of q after reset. Must be < MODULUS; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- up_dn  input  1  1 = count up, 0 = count down; sampled with en.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational; cascade enable for the next stage.
- wrap  output  1  registered one-cycle pulse, high while q shows the value just wrapped to.

Behaviour:
- One clock; reset is synchronous and active-high, named reset. Clock is named clk.
- Priority each posedge: reset > load > en > hold.
- Reset:
  - q = RESET_VAL, wrap = 0.
  - Takes effect at the next edge regardless of load/en; a count in progress is abandoned.
- Load:
  - q = load_val if load_val < MODULUS, else q = MODULUS-1 (clamped).
  - wrap = 0. en is ignored that cycle.
- en=1, up_dn=1:
  - q < MODULUS-1: q+1.
  - q == MODULUS-1, SATURATE=0: q = 0, wrap = 1.
  - q == MODULUS-1, SATURATE=1: q holds, wrap = 0.
- en=1, up_dn=0:
  - q > 0: q-1.
  - q == 0, SATURATE=0: q = MODULUS-1, wrap = 1.
  - q == 0, SATURATE=1: q holds, wrap = 0.
- en=0 and load=0: q holds, wrap = 0.
- tc:
  - tc = en & (up_dn ? q == MODULUS-1 : q == 0).
  - Asserted in SATURATE mode too.
  - Never gated by load or reset (downstream stages apply their own priority).
- Arithmetic:
  - Next-value compare and step computed at WIDTH+1 bits.
  - q never leaves 0..MODULUS-1 when MODULUS < 2**WIDTH.
- Latency: q and wrap update one cycle after the sampled inputs; tc follows q/en/up_dn combinationally.
- Direction change takes effect on the first enabled cycle it is sampled; no dead cycle.

Optional Feature:
- Macro: MOD_UPDOWN_COUNTER_OVF_EN.
- When defined, adds output port ovf (1 bit, registered sticky flag):
  - Set on any wrap, and on any enabled step attempted at the boundary while SATURATE=1.
  - Cleared by reset or load. Stays set otherwise.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package counter_pkg holds:
  - Direction constants DIR_UP=1'b1, DIR_DN=1'b0.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - A function clog2 for callers deriving WIDTH from MODULUS.
- One natural sub-module: mod_counter_next.
  - Purely combinational; inputs q, up_dn, en.
  - Outputs next_q, at_boundary, wrap_next.
  - Parametrised by WIDTH/MODULUS/SATURATE.
  - The top holds only the registers, load clamp and priority mux.

Test Plan (WIDTH=4, MODULUS=10, SATURATE=0, RESET_VAL=0 unless stated):
- reset=1 for 2 cycles with en=1, load=1, load_val=7 -> q=0, wrap=0 after first edge. Then en=1, up_dn=1 for 12 cycles -> q=1..9,0,1,2; wrap=1 only on the cycle q returns to 0.
- q=0, en=1, up_dn=0 -> q=9, wrap=1 for one cycle; tc=1 during the cycle q=0 with en=1, up_dn=0.
- load=1, load_val=13 with en=1 -> q=9 (clamped), wrap=0. Next cycle load=1, load_val=4 -> q=4.
- SATURATE=1: count up from 8 for 3 cycles -> q=9,9,9, wrap never asserts, tc=1 while q=9; with MOD_UPDOWN_COUNTER_OVF_EN, ovf=1 after the first held step, cleared by load.
- Two-stage cascade (stage1 en = stage0 tc), counting up from 00 for 25 cycles -> {stage1,stage0} = 2,5.
- Reset asserted mid-count at q=6 with en=1 and RESET_VAL=3 -> q=3 next edge, wrap=0, counting resumes from 3 after release.
